// File: rtl/block_c_src.sv
// -----------------------------------------------------------------------------
// block_c_src
//
// Command source for blockC's two inbound channels. Upstream commands arrive
// on a ready/valid port, wait in a small FIFO, and are dispatched strictly in
// order. Each command goes either to the eh2c ready/valid channel (source side)
// or to the b2C request/acknowledge channel (initiator side).
//
// Parameters
//   DATA_W      payload width
//   FIFO_DEPTH  command FIFO entries (power of 2, >= 2)
//   ACK_TO      cycles b2c_req may stay high without b2c_ack (1..65535)
//
// Ports
//   clk, rst     rising-edge clock; asynchronous active-high reset
//   cmd_valid    in   upstream command valid
//   cmd_ready    out  command FIFO has room (registered)
//   cmd_data     in   command payload
//   cmd_dst      in   0 = eh2c, 1 = b2C
//   eh2c_valid   out  eh2c source valid
//   eh2c_ready   in   eh2c sink ready
//   eh2c_data    out  eh2c payload, stable while eh2c_valid is high
//   b2c_req      out  b2C request (return-to-zero)
//   b2c_ack      in   b2C acknowledge
//   b2c_data     out  b2C payload, stable while b2c_req is high
//   busy         out  FIFO non-empty or a transfer still in progress
//   timeout_err  out  sticky flag, set when a b2C request gets no ack in time
//   sent_cnt     out  completed transfers on both channels, wraps at 16 bits
// -----------------------------------------------------------------------------
module block_c_src #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ACK_TO     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_dst,
  output logic              eh2c_valid,
  input  logic              eh2c_ready,
  output logic [DATA_W-1:0] eh2c_data,
  output logic              b2c_req,
  input  logic              b2c_ack,
  output logic [DATA_W-1:0] b2c_data,
  output logic              busy,
  output logic              timeout_err,
  output logic [15:0]       sent_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Pointer pattern that means "full": same index, opposite wrap bit.
  localparam logic [PTR_W:0] FULL_PAT = {1'b1, {PTR_W{1'b0}}};
  localparam logic [PTR_W:0] PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};

  // The wait counter holds the number of request cycles already spent, so
  // the last permitted request cycle is the one where it equals ACK_TO-1.
  localparam logic [15:0] ACK_LAST = 16'(ACK_TO - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RV_SEND = 2'd1,
    RA_REQ  = 2'd2,
    RA_GAP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [DATA_W:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic              cmd_ready_q, cmd_ready_d;
  state_t            state_q, state_d;
  logic [15:0]       wait_q, wait_d;
  logic [DATA_W-1:0] eh2c_data_q, eh2c_data_d;
  logic [DATA_W-1:0] b2c_data_q, b2c_data_d;
  logic              timeout_err_q, timeout_err_d;
  logic [15:0]       sent_cnt_q, sent_cnt_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic              empty;
  logic              push;
  logic              pop;
  logic              full_d;
  logic [DATA_W:0]   head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = cmd_valid & cmd_ready_q;
  assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

  // ---------------------------------------------------------------------------
  // FIFO storage. Entries need no reset: the pointers define which are live.
  // Each entry is {dst, data}.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= {cmd_dst, cmd_data};
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and the registered ready. Ready is derived from the pointers
  // as they will be after this edge, so it always equals !full of the current
  // state; a push therefore can never land on a full FIFO even when a pop
  // happens in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    full_d      = ((wr_ptr_d ^ rd_ptr_d) == FULL_PAT);
    cmd_ready_d = ~full_d;
  end

  // ---------------------------------------------------------------------------
  // Dispatch FSM, next-state and register updates.
  // IDLE pops the head command and latches its payload into the register of
  // the chosen channel; the other channel's payload register is left alone.
  // RV_SEND holds valid until ready. RA_REQ holds req until ack or timeout;
  // an ack on the final permitted cycle still counts as a completed transfer.
  // RA_GAP forces req low and waits for ack to return to zero so that a held
  // ack cannot be mistaken for the acknowledge of the next request.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    eh2c_data_d   = eh2c_data_q;
    b2c_data_d    = b2c_data_q;
    timeout_err_d = timeout_err_q;
    sent_cnt_d    = sent_cnt_q;
    pop           = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop    = 1'b1;
          wait_d = '0;
          if (head[DATA_W]) begin
            b2c_data_d = head[DATA_W-1:0];
            state_d    = RA_REQ;
          end else begin
            eh2c_data_d = head[DATA_W-1:0];
            state_d     = RV_SEND;
          end
        end
      end

      RV_SEND: begin
        if (eh2c_ready) begin
          sent_cnt_d = sent_cnt_q + 16'd1;
          state_d    = IDLE;
        end
      end

      RA_REQ: begin
        if (b2c_ack) begin
          sent_cnt_d = sent_cnt_q + 16'd1;
          state_d    = RA_GAP;
        end else if (wait_q == ACK_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = RA_GAP;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end

      RA_GAP: begin
        if (!b2c_ack) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset empties the FIFO, returns the FSM to IDLE and drops
  // valid/req immediately because both are decoded straight from the state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cmd_ready_q   <= 1'b1;
      state_q       <= IDLE;
      wait_q        <= '0;
      eh2c_data_q   <= '0;
      b2c_data_q    <= '0;
      timeout_err_q <= 1'b0;
      sent_cnt_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cmd_ready_q   <= cmd_ready_d;
      state_q       <= state_d;
      wait_q        <= wait_d;
      eh2c_data_q   <= eh2c_data_d;
      b2c_data_q    <= b2c_data_d;
      timeout_err_q <= timeout_err_d;
      sent_cnt_q    <= sent_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, all taken from registers so nothing combinational reaches a port
  // from an input.
  // ---------------------------------------------------------------------------
  assign cmd_ready   = cmd_ready_q;
  assign eh2c_valid  = (state_q == RV_SEND);
  assign eh2c_data   = eh2c_data_q;
  assign b2c_req     = (state_q == RA_REQ);
  assign b2c_data    = b2c_data_q;
  assign busy        = ~empty | (state_q != IDLE);
  assign timeout_err = timeout_err_q;
  assign sent_cnt    = sent_cnt_q;

endmodule

// File: tb/tb_block_c_src.sv
// -----------------------------------------------------------------------------
// tb_block_c_src
//
// Directed bench for block_c_src. A transaction-level model (a queue of
// pending commands plus the transfer currently on a channel) predicts every
// output each cycle; hand-computed literal expectations pin the scenarios.
// -----------------------------------------------------------------------------
module tb_block_c_src;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int ACK_TO = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_dst;
  logic              eh2c_valid;
  logic              eh2c_ready;
  logic [DATA_W-1:0] eh2c_data;
  logic              b2c_req;
  logic              b2c_ack;
  logic [DATA_W-1:0] b2c_data;
  logic              busy;
  logic              timeout_err;
  logic [15:0]       sent_cnt;

  int checks   = 0;
  int failures = 0;

  block_c_src #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(DEPTH),
    .ACK_TO    (ACK_TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .cmd_dst    (cmd_dst),
    .eh2c_valid (eh2c_valid),
    .eh2c_ready (eh2c_ready),
    .eh2c_data  (eh2c_data),
    .b2c_req    (b2c_req),
    .b2c_ack    (b2c_ack),
    .b2c_data   (b2c_data),
    .busy       (busy),
    .timeout_err(timeout_err),
    .sent_cnt   (sent_cnt)
  );

  always #5 clk = ~clk;

  // Model: commands waiting in order, and what is currently on the wire.
  // mdl_busy_kind: 0 nothing in flight, 1 beat offered on eh2c,
  // 2 request raised on b2C, 3 request done and waiting for ack to fall.
  logic [DATA_W:0]   mdl_q[$];
  int                mdl_busy_kind;
  int                mdl_req_cycles;
  logic [DATA_W-1:0] mdl_eh2c_data;
  logic [DATA_W-1:0] mdl_b2c_data;
  logic [15:0]       mdl_cnt;
  logic              mdl_terr;

  task automatic modelReset();
    mdl_q.delete();
    mdl_busy_kind  = 0;
    mdl_req_cycles = 0;
    mdl_eh2c_data  = '0;
    mdl_b2c_data   = '0;
    mdl_cnt        = '0;
    mdl_terr       = 1'b0;
  endtask

  // One clock edge worth of behaviour, using the inputs held across the edge.
  task automatic modelStep();
    logic            room;
    logic [DATA_W:0] cmd;
    room = (mdl_q.size() < DEPTH);
    case (mdl_busy_kind)
      0: begin
        if (mdl_q.size() > 0) begin
          cmd = mdl_q.pop_front();
          mdl_req_cycles = 0;
          if (cmd[DATA_W]) begin
            mdl_b2c_data  = cmd[DATA_W-1:0];
            mdl_busy_kind = 2;
          end else begin
            mdl_eh2c_data = cmd[DATA_W-1:0];
            mdl_busy_kind = 1;
          end
        end
      end
      1: begin
        if (eh2c_ready) begin
          mdl_cnt       = mdl_cnt + 16'd1;
          mdl_busy_kind = 0;
        end
      end
      2: begin
        mdl_req_cycles = mdl_req_cycles + 1;
        if (b2c_ack) begin
          mdl_cnt       = mdl_cnt + 16'd1;
          mdl_busy_kind = 3;
        end else if (mdl_req_cycles >= ACK_TO) begin
          mdl_terr      = 1'b1;
          mdl_busy_kind = 3;
        end
      end
      default: begin
        if (!b2c_ack) mdl_busy_kind = 0;
      end
    endcase
    if (cmd_valid && room) mdl_q.push_back({cmd_dst, cmd_data});
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("cmd_ready",   32'(cmd_ready),   32'(mdl_q.size() < DEPTH));
    checkOutput("eh2c_valid",  32'(eh2c_valid),  32'(mdl_busy_kind == 1));
    checkOutput("eh2c_data",   32'(eh2c_data),   32'(mdl_eh2c_data));
    checkOutput("b2c_req",     32'(b2c_req),     32'(mdl_busy_kind == 2));
    checkOutput("b2c_data",    32'(b2c_data),    32'(mdl_b2c_data));
    checkOutput("busy",        32'(busy),        32'((mdl_q.size() > 0) || (mdl_busy_kind != 0)));
    checkOutput("timeout_err", 32'(timeout_err), 32'(mdl_terr));
    checkOutput("sent_cnt",    32'(sent_cnt),    32'(mdl_cnt));
  endtask

  // Advance one cycle: model follows the rising edge, outputs are compared on
  // the falling edge, and the caller then drives the next inputs.
  task automatic tick();
    @(posedge clk);
    if (!rst) modelStep();
    @(negedge clk);
    if (!rst) compareAll();
  endtask

  task automatic doReset();
    rst = 1'b1;
    modelReset();
    cmd_valid  = 1'b0;
    cmd_data   = '0;
    cmd_dst    = 1'b0;
    eh2c_ready = 1'b0;
    b2c_ack    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one command until it is accepted; returns after the accepting edge.
  task automatic applyStimulus(input logic dst, input logic [DATA_W-1:0] data);
    logic accepted;
    accepted  = 1'b0;
    cmd_dst   = dst;
    cmd_data  = data;
    cmd_valid = 1'b1;
    for (int n = 0; n < 40 && !accepted; n++) begin
      accepted = (mdl_q.size() < DEPTH);
      tick();
    end
    cmd_valid = 1'b0;
    if (!accepted) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_wait actual=not_accepted expected=accepted data=%0h", data);
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] cap[$];
    int                req_seen;
    logic [DATA_W-1:0] exp_order[5];

    #1;
    doReset();

    // Reset values.
    checkOutput("rst_cmd_ready",   32'(cmd_ready),   32'd1);
    checkOutput("rst_eh2c_valid",  32'(eh2c_valid),  32'd0);
    checkOutput("rst_b2c_req",     32'(b2c_req),     32'd0);
    checkOutput("rst_busy",        32'(busy),        32'd0);
    checkOutput("rst_sent_cnt",    32'(sent_cnt),    32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);

    // Single eh2c beat with ready tied high.
    $display("[TB] scenario 1: eh2c single beat");
    eh2c_ready = 1'b1;
    applyStimulus(1'b0, 8'hA5);
    checkOutput("s1_valid_c1", 32'(eh2c_valid), 32'd0);
    tick();
    checkOutput("s1_valid_c2", 32'(eh2c_valid), 32'd1);
    checkOutput("s1_data",     32'(eh2c_data),  32'hA5);
    tick();
    checkOutput("s1_valid_c3", 32'(eh2c_valid), 32'd0);
    checkOutput("s1_sent_cnt", 32'(sent_cnt),   32'd1);

    // b2C request acknowledged on its fourth cycle.
    $display("[TB] scenario 2: b2C req/ack");
    doReset();
    applyStimulus(1'b1, 8'h3C);
    tick();
    checkOutput("s2_req_r0",  32'(b2c_req),  32'd1);
    checkOutput("s2_data",    32'(b2c_data), 32'h3C);
    tick();
    tick();
    tick();
    checkOutput("s2_req_r3",  32'(b2c_req),  32'd1);
    b2c_ack = 1'b1;
    tick();
    checkOutput("s2_req_r4",  32'(b2c_req),  32'd0);
    checkOutput("s2_sent",    32'(sent_cnt), 32'd1);
    b2c_ack = 1'b0;
    tick();
    checkOutput("s2_req_gap", 32'(b2c_req),  32'd0);

    // Five eh2c commands against a stalled sink, then release in order.
    $display("[TB] scenario 3: FIFO fill and ordered drain");
    eh2c_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'(8'h10 + i));
    checkOutput("s3_cmd_ready_full", 32'(cmd_ready), 32'd0);
    checkOutput("s3_busy",           32'(busy),      32'd1);
    tick();
    tick();
    checkOutput("s3_hold_data", 32'(eh2c_data), 32'h10);
    eh2c_ready = 1'b1;
    cap.delete();
    for (int i = 0; i < 20; i++) begin
      if (eh2c_valid) cap.push_back(eh2c_data);
      tick();
    end
    exp_order = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    checkOutput("s3_beats", 32'(cap.size()), 32'd5);
    for (int i = 0; i < 5 && i < cap.size(); i++) begin
      checkOutput($sformatf("s3_beat%0d", i), 32'(cap[i]), 32'(exp_order[i]));
    end
    checkOutput("s3_sent", 32'(sent_cnt), 32'd6);

    // b2C timeout; the following eh2c command must still go out.
    $display("[TB] scenario 4: ack timeout");
    applyStimulus(1'b1, 8'h77);
    applyStimulus(1'b0, 8'h88);
    req_seen = 0;
    cap.delete();
    for (int i = 0; i < 30; i++) begin
      if (b2c_req) req_seen++;
      if (eh2c_valid) cap.push_back(eh2c_data);
      tick();
    end
    checkOutput("s4_req_cycles", 32'(req_seen),    32'd8);
    checkOutput("s4_timeout",    32'(timeout_err), 32'd1);
    checkOutput("s4_next_beats", 32'(cap.size()),  32'd1);
    if (cap.size() > 0) checkOutput("s4_next_data", 32'(cap[0]), 32'h88);
    checkOutput("s4_sent",       32'(sent_cnt),    32'd7);

    // Reset in the middle of an eh2c beat with three commands queued.
    $display("[TB] scenario 5: reset mid transfer");
    eh2c_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'(8'h20 + i));
    checkOutput("s5_valid_before", 32'(eh2c_valid), 32'd1);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("s5_valid",     32'(eh2c_valid),  32'd0);
    checkOutput("s5_busy",      32'(busy),        32'd0);
    checkOutput("s5_cmd_ready", 32'(cmd_ready),   32'd1);
    checkOutput("s5_sent",      32'(sent_cnt),    32'd0);
    checkOutput("s5_timeout",   32'(timeout_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    eh2c_ready = 1'b1;
    tick();
    tick();
    checkOutput("s5_no_replay", 32'(eh2c_valid), 32'd0);

    // Counter wrap, held ack across the gap, and ack on the final cycle.
    $display("[TB] scenario 6: counter wrap and ack corner cases");
    force dut.sent_cnt_q = 16'hFFFD;
    mdl_cnt = 16'hFFFD;
    tick();
    release dut.sent_cnt_q;
    applyStimulus(1'b1, 8'hC1);
    applyStimulus(1'b1, 8'hC2);
    checkOutput("s6_req1",      32'(b2c_req),  32'd1);
    checkOutput("s6_req1_data", 32'(b2c_data), 32'hC1);
    b2c_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("s6_gap_req%0d", i), 32'(b2c_req), 32'd0);
    end
    checkOutput("s6_sent_fffe", 32'(sent_cnt), 32'hFFFE);
    b2c_ack = 1'b0;
    tick();
    tick();
    checkOutput("s6_req2",      32'(b2c_req),  32'd1);
    checkOutput("s6_req2_data", 32'(b2c_data), 32'hC2);
    for (int i = 0; i < 7; i++) tick();
    checkOutput("s6_req2_last", 32'(b2c_req),  32'd1);
    b2c_ack = 1'b1;
    tick();
    checkOutput("s6_sent_ffff",   32'(sent_cnt),    32'hFFFF);
    checkOutput("s6_ack_wins",    32'(timeout_err), 32'd0);
    b2c_ack = 1'b0;
    tick();
    applyStimulus(1'b0, 8'hE0);
    tick();
    tick();
    checkOutput("s6_sent_wrap", 32'(sent_cnt), 32'd0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
